// File: rtl/data_mem_pkg.sv
// Shared processor datapath constants and types: byte-wide data, 8-bit
// addresses, and the derived memory depth.
package data_mem_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] byte_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/data_mem_if.sv
// MEM-stage data memory bus: write/read enables, a shared address, write data
// and read data.
interface data_mem_if;
  import data_mem_pkg::*;

  logic  WE;
  logic  RE;
  addr_t A;
  byte_t WD;
  byte_t RD;

  modport master (output WE, output RE, output A, output WD, input RD);
  modport slave  (input WE, input RE, input A, input WD, output RD);

endinterface

// File: rtl/data_mem.sv
// 256 x 8 register-based data memory with a synchronous write port and a
// combinational read port gated by the read enable.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int DATA_W = data_mem_pkg::DATA_W,
  parameter int ADDR_W = data_mem_pkg::ADDR_W,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input logic       Clk,
  input logic       Rst,
  data_mem_if.slave bus
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset wipes every location and takes priority over a write on the same edge.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      mem <= '{default: '0};
    end else if (bus.WE) begin
      mem[bus.A] <= bus.WD;
    end
  end

  // Read-before-write: a same-cycle write only becomes visible after the edge.
  assign bus.RD = bus.RE ? mem[bus.A] : '0;

endmodule

// File: tb/tb_data_mem.sv
// Directed-vector bench for data_mem: reset clear, write/readback, read
// gating, same-cycle read/write, reset priority and boundary addresses.
module tb_data_mem;
  import data_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  data_mem_if bus ();

  data_mem dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input byte_t got, input byte_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input addr_t addr, input byte_t data);
    bus.WE = 1'b1;
    bus.A  = addr;
    bus.WD = data;
    tick();
    bus.WE = 1'b0;
  endtask

  task automatic read_chk(input string tag, input addr_t addr, input byte_t exp);
    bus.RE = 1'b1;
    bus.A  = addr;
    #1;
    check(tag, bus.RD, exp);
  endtask

  initial begin
    addr_t clr_addrs [5] = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h06};

    bus.WE = 1'b0;
    bus.RE = 1'b0;
    bus.A  = '0;
    bus.WD = '0;

    // Reset clear
    rst = 1'b0;
    tick();
    rst = 1'b1;
    foreach (clr_addrs[i]) read_chk($sformatf("reset_clr_%02h", clr_addrs[i]), clr_addrs[i], 8'h00);

    // Write / readback, neighbour untouched
    write(8'h50, 8'hAA);
    read_chk("wr_rd_50", 8'h50, 8'hAA);
    read_chk("neighbour_51", 8'h51, 8'h00);

    // Read gating, combinational re-enable
    write(8'h10, 8'h3C);
    bus.RE = 1'b0;
    bus.A  = 8'h10;
    #1;
    check("gated_re0", bus.RD, 8'h00);
    bus.RE = 1'b1;
    #1;
    check("ungated_re1", bus.RD, 8'h3C);

    // Same-cycle write and read
    write(8'h20, 8'h11);
    bus.WE = 1'b1;
    bus.RE = 1'b1;
    bus.A  = 8'h20;
    bus.WD = 8'h99;
    #1;
    check("rbw_before_edge", bus.RD, 8'h11);
    tick();
    check("rbw_after_edge", bus.RD, 8'h99);
    bus.WE = 1'b0;

    // WE=0 leaves memory unchanged
    bus.A  = 8'h20;
    bus.WD = 8'h33;
    tick();
    check("we0_hold", bus.RD, 8'h99);

    // Reset priority over write, and full wipe
    read_chk("pre_reset_50", 8'h50, 8'hAA);
    rst    = 1'b0;
    bus.WE = 1'b1;
    bus.WD = 8'h55;
    #1;
    check("rst_midcycle_no_effect", bus.RD, 8'hAA);
    tick();
    rst    = 1'b1;
    bus.WE = 1'b0;
    read_chk("rst_beats_write_50", 8'h50, 8'h00);
    read_chk("rst_wipe_10", 8'h10, 8'h00);
    read_chk("rst_wipe_20", 8'h20, 8'h00);

    // Boundary addresses, no aliasing
    write(8'hFF, 8'h01);
    write(8'h00, 8'h7E);
    read_chk("bound_ff", 8'hFF, 8'h01);
    read_chk("bound_00", 8'h00, 8'h7E);
    read_chk("bound_7f", 8'h7F, 8'h00);
    read_chk("bound_80", 8'h80, 8'h00);
    bus.RE = 1'b0;
    bus.A  = 8'hFF;
    #1;
    check("bound_gated_ff", bus.RD, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Byte-wide data memory for the MEM stage of the 8-bit pipelined processor.
- 256 x 8 register-based storage with a synchronous write port and a combinational, read-enable-gated read port.
- Synchronous active-low reset clears every location to 0x00.
- Addressed directly by the ALU/address result; RD feeds the MEM/WB pipeline register.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 8, address width in bits.
- DEPTH, 2**ADDR_W (256), number of words; must equal 2**ADDR_W.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Rst  input  1  reset, synchronous, active-low; sampled on rising edge of Clk.
- WE  input  1  write enable, active-high.
- RE  input  1  read enable, active-high.
- A  input  ADDR_W  word address, shared by read and write.
- WD  input  DATA_W  write data.
- RD  output  DATA_W  read data.

Behaviour:
- Clocking and reset:
  - One clock domain (Clk).
  - Reset is synchronous and active-low: on a rising Clk edge with Rst=0, all DEPTH locations become 0x00.
  - Reset has priority over a write: WE is ignored on an edge where Rst=0.
- Write:
  - On a rising Clk edge with Rst=1 and WE=1, mem[A] <= WD.
  - Write latency 1 cycle; the new value is visible on RD immediately after that edge.
  - WE=0 leaves memory unchanged.
- Read:
  - Combinational: RD = mem[A] when RE=1; RD = 0x00 when RE=0.
  - No clock latency; RD follows A, RE and memory contents within the same cycle.
- Simultaneous WE=1, RE=1, same address:
  - RD shows the old contents until the clock edge, then the new WD (read-before-write within the cycle).
  - No internal bypass.
- Reset outputs:
  - RD is not a register.
  - After reset, RD = 0x00 for any A, because all contents are 0x00 (RE=1) or the read is gated (RE=0).
  - Reset asserted mid-cycle has no effect until the next rising edge.
- Address range: all 8-bit addresses valid (0x00–0xFF); no wrap or out-of-range handling required.
- X handling: RD must never be X after the first reset edge when A, RE are known.
- Memory contents persist indefinitely without reset; there are no other side effects.

Decomposition:
- Shared processor package holds DATA_W=8 and ADDR_W=8 constants and a byte_t/addr_t typedef used by the datapath.
- No sub-module. Storage array, reset/write always block and read mux live in data_mem.

Test Plan:
- Reset clear: Rst=0 for one edge, then Rst=1, RE=1, A=0x00/0x01/0x02/0x05/0x06 -> RD=0x00 each.
- Write/readback: WE=1, A=0x50, WD=0xAA for one edge, WE=0, RE=1, A=0x50 -> RD=0xAA. A=0x51 -> RD=0x00 (neighbour untouched).
- Read gating: after writing 0x3C to 0x10, RE=0, A=0x10 -> RD=0x00. RE=1 -> RD=0x3C combinationally, no clock needed.
- Same-cycle write/read: mem[0x20]=0x11, then WE=1, RE=1, A=0x20, WD=0x99:
  - RD=0x11 before the edge.
  - RD=0x99 after the edge.
- Reset priority and wipe: WE=1, A=0x50, WD=0x55 on an edge with Rst=0 -> RD at 0x50 = 0x00. A previously written 0xAA at 0x50 is also cleared.
- Boundary addresses: write 0xFF->0x01 and 0x00->0x7E, each for one edge. Read back -> RD=0x01 at A=0xFF, 0x7E at A=0x00, with no aliasing between them.
